// File: rtl/mult_hilo_ctrl_pkg.sv
// mult_hilo_ctrl_pkg: shared state encoding and default sizing for the HI/LO multiply controller.
package mult_hilo_ctrl_pkg;
  localparam int W_DEF = 32;
  localparam int MULT_LAT_DEF = 2;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
endpackage

// File: rtl/mult_hilo_ctrl_unsigned_fix.sv
// mult_unsigned_fix: turns a signed 2W-bit product into the unsigned product of the same operands.
module mult_unsigned_fix
  import mult_hilo_ctrl_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [2*W-1:0] z,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           sgn,
  output logic [2*W-1:0] res
);
  logic [2*W-1:0] fa, fb;
  // An operand with its top bit set was read as value-2^W, so add the other operand back in at weight 2^W.
  assign fa = a[W-1] ? {b, {W{1'b0}}} : '0;
  assign fb = b[W-1] ? {a, {W{1'b0}}} : '0;
  assign res = sgn ? z : z + fa + fb;
endmodule

// File: rtl/mult_hilo_ctrl.sv
// mult_hilo_ctrl: issues multiplies to an external pipelined multiplier and writes the product into HI/LO.
// Define MULT_UNSIGNED_EN to honour req_signed and build the unsigned-product correction.
module mult_hilo_ctrl
  import mult_hilo_ctrl_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int MULT_LAT = MULT_LAT_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_signed,
  input  logic [W-1:0]   req_a,
  input  logic [W-1:0]   req_b,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_z,
  input  logic           wr_hi,
  input  logic           wr_lo,
  input  logic [W-1:0]   wr_data,
  output logic [W-1:0]   hi,
  output logic [W-1:0]   lo,
  output logic           busy,
  output logic           done
);
  localparam int CW = $clog2(MULT_LAT + 1);
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [2*W-1:0] prod;
  assign req_ready = (state == IDLE);
`ifdef MULT_UNSIGNED_EN
  logic sgn;
  always_ff @(posedge clk or negedge reset)
    if (!reset) sgn <= 1'b1;
    else if (state == IDLE && req_valid) sgn <= req_signed;
  mult_unsigned_fix #(.W(W)) u_fix (
    .z(mul_z),
    .a(mul_a),
    .b(mul_b),
    .sgn(sgn),
    .res(prod)
  );
`else
  logic unused_signed;
  assign unused_signed = req_signed;
  assign prod = mul_z;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      mul_a <= '0;
      mul_b <= '0;
      hi <= '0;
      lo <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          mul_a <= req_a;
          mul_b <= req_b;
          cnt <= CW'(MULT_LAT - 1);
          busy <= 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= (cnt == 0) ? cnt : cnt - 1'b1;
          if (cnt == 0) state <= CAPTURE;
        end
        CAPTURE: begin
          {hi, lo} <= prod;
          busy <= 1'b0;
          done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // The multiply result owns HI/LO in the capture cycle; direct writes there are dropped.
      if (state != CAPTURE) begin
        if (wr_hi) hi <= wr_data;
        if (wr_lo) lo <= wr_data;
      end
    end
endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// tb_mult_hilo_ctrl: directed checks of the HI/LO multiply controller against a two-stage multiplier model.
module tb_mult_hilo_ctrl;
  localparam int W = 32;
  logic clk = 1'b0, reset = 1'b0, req_valid = 1'b0, req_signed = 1'b1, wr_hi = 1'b0, wr_lo = 1'b0;
  logic [W-1:0] req_a = '0, req_b = '0, wr_data = '0;
  logic req_ready, busy, done;
  logic [W-1:0] mul_a, mul_b, hi, lo;
  logic [2*W-1:0] mul_z = '0, p1 = '0;
  int checks = 0, errors = 0;

  mult_hilo_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_signed(req_signed), .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    p1 <= $signed(mul_a) * $signed(mul_b);
    mul_z <= p1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [W-1:0] eh, input logic [W-1:0] el);
    req_valid = 1'b1; req_a = a; req_b = b; req_signed = s;
    step;
    req_valid = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_mul_a"}, 64'(mul_a), 64'(a));
    step;
    step;
    chk({tag, "_early_done"}, 64'(done), 64'd0);
    step;
    chk({tag, "_hi"}, 64'(hi), 64'(eh));
    chk({tag, "_lo"}, 64'(lo), 64'(el));
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_busy_clr"}, 64'(busy), 64'd0);
    step;
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    repeat (2) step;
    reset = 1'b1;
    step;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_done", 64'(done), 64'd0);

    run_mul("signed", 32'hFFFFFFFD, 32'd7, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB);
`ifdef MULT_UNSIGNED_EN
    run_mul("unsigned", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001);
`else
    run_mul("unsigned_ignored", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h1);
`endif
    run_mul("signed_m1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h1);

    req_valid = 1'b1; req_a = 32'd5; req_b = 32'd6; req_signed = 1'b1;
    step;
    req_a = 32'd100; req_b = 32'd100;
    step;
    chk("held_mul_a", 64'(mul_a), 64'd5);
    chk("held_ready", 64'(req_ready), 64'd0);
    step;
    step;
    chk("held_hi", 64'(hi), 64'd0);
    chk("held_lo", 64'(lo), 64'd30);
    chk("held_mul_b", 64'(mul_b), 64'd6);
    step;
    chk("second_mul_a", 64'(mul_a), 64'd100);
    chk("second_busy", 64'(busy), 64'd1);
    req_valid = 1'b0;
    repeat (3) step;
    chk("second_lo", 64'(lo), 64'd10000);
    chk("second_hi", 64'(hi), 64'd0);
    step;

    wr_hi = 1'b1; wr_data = 32'h12345678;
    step;
    wr_hi = 1'b0;
    chk("wrhi_hi", 64'(hi), 64'h12345678);
    chk("wrhi_lo", 64'(lo), 64'd10000);
    wr_lo = 1'b1; wr_data = 32'hDEADBEEF;
    step;
    wr_lo = 1'b0;
    chk("wrlo_lo", 64'(lo), 64'hDEADBEEF);

    req_valid = 1'b1; req_a = 32'd2; req_b = 32'd3;
    step;
    req_valid = 1'b0;
    step;
    step;
    wr_lo = 1'b1; wr_data = 32'hCAFEF00D;
    step;
    wr_lo = 1'b0;
    chk("cap_lo", 64'(lo), 64'd6);
    chk("cap_hi", 64'(hi), 64'd0);
    chk("cap_done", 64'(done), 64'd1);
    step;

    wr_hi = 1'b1; wr_data = 32'h0BADBEEF;
    step;
    wr_hi = 1'b0;
    req_valid = 1'b1; req_a = 32'd7; req_b = 32'd9;
    step;
    req_valid = 1'b0;
    chk("abort_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    chk("abort_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      chk("abort_no_done", 64'(done), 64'd0);
    end
    chk("abort_hi_after", 64'(hi), 64'd0);
    chk("abort_lo_after", 64'(lo), 64'd0);
    chk("abort_ready_after", 64'(req_ready), 64'd1);
    chk("abort_busy_after", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
